// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int          WORD_BYTES = 4;

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage, combinational read; second read port for word W+1 under IMEM_PREFETCH_EN.
// Write port is for loading only; the responder ties it off and contents are preloaded externally.
module imem_array #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [31:0]      wr_dat_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [31:0]      rd_dat_o
`ifdef IMEM_PREFETCH_EN
    ,
    input  logic [IDX_W-1:0] rd_nxt_idx_i,
    output logic [31:0]      rd_nxt_dat_o
`endif
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_idx_i] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem[rd_idx_i];

`ifdef IMEM_PREFETCH_EN
    assign rd_nxt_dat_o = mem[rd_nxt_idx_i];
`endif

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: one outstanding request, WAIT_CYCLES+1 latency (errors/prefetch hits 1), no response backpressure.
// IMEM_PREFETCH_EN adds a one-entry next-word buffer filled on each good response.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              req_ready_o,
    input  logic              flush_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_instr_o,
    output logic              resp_err_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W - 2)'(DEPTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        resp_instr_q, resp_instr_d;
    logic               resp_err_q, resp_err_d;

    logic [ADDR_W-3:0]  req_widx;
    logic               req_err;
    logic               accept;
    logic [IDX_W-1:0]   rd_idx;
    logic [31:0]        rd_dat;

    assign req_widx    = req_addr_i[ADDR_W-1:2];
    assign req_err     = (req_addr_i[1:0] != 2'b00) || (req_widx >= DEPTH_LIM);
    assign req_ready_o = (state_q == IDLE) && !flush_i;
    assign accept      = req_valid_i && req_ready_o;

    // In IDLE the incoming address is read directly so WAIT_CYCLES==0 can respond next cycle.
    assign rd_idx = (state_q == IDLE) ? req_widx[IDX_W-1:0] : idx_q;

`ifdef IMEM_PREFETCH_EN
    logic               buf_vld_q, buf_vld_d;
    logic [IDX_W-1:0]   buf_idx_q, buf_idx_d;
    logic [31:0]        buf_dat_q, buf_dat_d;
    logic [IDX_W:0]     nxt_idx;
    logic               nxt_in_range;
    logic [31:0]        rd_nxt_dat;
    logic               pf_hit;

    assign nxt_idx      = {1'b0, idx_q} + 1'b1;
    assign nxt_in_range = nxt_idx < (IDX_W + 1)'(DEPTH);
    // A misaligned address can share the buffered word index, so errors never hit.
    assign pf_hit       = buf_vld_q && !req_err && (req_widx[IDX_W-1:0] == buf_idx_q);
`endif

    imem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i        (clk_i),
        .wr_en_i      (1'b0),
        .wr_idx_i     ('0),
        .wr_dat_i     ('0),
        .rd_idx_i     (rd_idx),
        .rd_dat_o     (rd_dat)
`ifdef IMEM_PREFETCH_EN
        ,
        .rd_nxt_idx_i (nxt_idx[IDX_W-1:0]),
        .rd_nxt_dat_o (rd_nxt_dat)
`endif
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        resp_instr_d = resp_instr_q;
        resp_err_d   = resp_err_q;
`ifdef IMEM_PREFETCH_EN
        buf_vld_d    = buf_vld_q;
        buf_idx_d    = buf_idx_q;
        buf_dat_d    = buf_dat_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d = req_widx[IDX_W-1:0];
`ifdef IMEM_PREFETCH_EN
                    // Hit consumes the entry, miss discards it.
                    buf_vld_d = 1'b0;
`endif
                    if (req_err) begin
                        state_d      = RESP;
                        resp_instr_d = NOP_INSTR;
                        resp_err_d   = 1'b1;
                    end
`ifdef IMEM_PREFETCH_EN
                    else if (pf_hit) begin
                        state_d      = RESP;
                        resp_instr_d = buf_dat_q;
                        resp_err_d   = 1'b0;
                    end
`endif
                    else if (WAIT_CYCLES == 0) begin
                        state_d      = RESP;
                        resp_instr_d = rd_dat;
                        resp_err_d   = 1'b0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d      = RESP;
                    resp_instr_d = rd_dat;
                    resp_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
`ifdef IMEM_PREFETCH_EN
                if (!flush_i && !resp_err_q && nxt_in_range) begin
                    buf_vld_d = 1'b1;
                    buf_idx_d = nxt_idx[IDX_W-1:0];
                    buf_dat_d = rd_nxt_dat;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
`ifdef IMEM_PREFETCH_EN
        if (flush_i) begin
            buf_vld_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            resp_instr_q <= NOP_INSTR;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            resp_instr_q <= resp_instr_d;
            resp_err_q   <= resp_err_d;
        end
    end

`ifdef IMEM_PREFETCH_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            buf_vld_q <= 1'b0;
            buf_idx_q <= '0;
            buf_dat_q <= '0;
        end else begin
            buf_vld_q <= buf_vld_d;
            buf_idx_q <= buf_idx_d;
            buf_dat_q <= buf_dat_d;
        end
    end
`endif

    // Flush in RESP suppresses the pulse; the data registers still hold the aborted response.
    assign resp_valid_o = (state_q == RESP) && !flush_i;
    assign resp_instr_o = resp_instr_q;
    assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with a latency-level reference model checked every cycle.
// Build with IMEM_PREFETCH_EN defined to exercise the prefetch buffer.
module tb_imem_responder;

    localparam int DEPTH = 256;
    localparam int WAITC = 2;
`ifdef IMEM_PREFETCH_EN
    localparam bit PF      = 1'b1;
    localparam int B2B_GAP = 2;
`else
    localparam bit PF      = 1'b0;
    localparam int B2B_GAP = 4;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic [31:0] req_addr_i;
    logic        req_ready_o;
    logic        flush_i;
    logic        resp_valid_o;
    logic [31:0] resp_instr_o;
    logic        resp_err_o;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] ref_mem [DEPTH];

    imem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAITC),
        .ADDR_W      (32)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_addr_i   (req_addr_i),
        .req_ready_o  (req_ready_o),
        .flush_i      (flush_i),
        .resp_valid_o (resp_valid_o),
        .resp_instr_o (resp_instr_o),
        .resp_err_o   (resp_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    function automatic logic [31:0] mem_val(input int i);
        case (i)
            0:       return 32'h2001_0005;
            1:       return 32'h2002_000A;
            2:       return 32'h0043_1820;
            3:       return 32'hAC03_0010;
            4:       return 32'h8C04_0020;
            255:     return 32'h1234_5678;
            default: return 32'hA500_0000 | 32'(i);
        endcase
    endfunction

    // Reference model: a request is described only by when its response is due and what it carries.
    bit          m_pend;
    int          m_resp_in;
    logic [31:0] m_p_instr;
    logic        m_p_err;
    logic [31:0] m_p_word;
    logic [31:0] m_instr;
    logic        m_err;
    bit          m_buf_vld;
    logic [31:0] m_buf_word;

    always @(negedge clk_i) begin
        logic [31:0] w;
        bit          e;
        bit          h;
        if (!rst_i) begin
            m_pend    = 1'b0;
            m_resp_in = 0;
            m_instr   = 32'h0;
            m_err     = 1'b0;
            m_buf_vld = 1'b0;
        end else if (m_pend && m_resp_in == 0) begin
            m_instr = m_p_instr;
            m_err   = m_p_err;
        end

        chk("model_ready", 32'(req_ready_o), 32'(!m_pend && !flush_i));
        chk("model_valid", 32'(resp_valid_o), 32'(m_pend && m_resp_in == 0 && !flush_i));
        chk("model_instr", resp_instr_o, m_instr);
        chk("model_err", 32'(resp_err_o), 32'(m_err));

        if (rst_i) begin
            if (m_pend) begin
                if (m_resp_in == 0) begin
                    m_pend = 1'b0;
                    if (PF && !flush_i && !m_p_err && (m_p_word + 1 < DEPTH)) begin
                        m_buf_vld  = 1'b1;
                        m_buf_word = m_p_word + 1;
                    end
                end else if (flush_i) begin
                    m_pend = 1'b0;
                end else begin
                    m_resp_in--;
                end
            end else if (req_valid_i && !flush_i) begin
                w = req_addr_i >> 2;
                e = (req_addr_i[1:0] != 2'b00) || (w >= DEPTH);
                h = PF && m_buf_vld && !e && (w == m_buf_word);
                m_pend    = 1'b1;
                m_resp_in = (e || h) ? 0 : WAITC;
                m_p_err   = e;
                m_p_word  = w;
                m_p_instr = e ? 32'h0 : ref_mem[w];
                m_buf_vld = 1'b0;
            end
            if (flush_i) m_buf_vld = 1'b0;
        end
    end

    // Issues one request; lat counts cycles from the accept cycle to the response cycle.
    task automatic do_req(input logic [31:0] addr, output int lat, output logic [31:0] ins,
                          output logic er, output int nrdy);
        bit got;
        @(posedge clk_i); #1;
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        got = 1'b0;
        lat = 0; ins = 32'hx; er = 1'bx; nrdy = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk_i);
            got = req_ready_o;
        end
        if (!got) begin
            timeout("req_accept");
            req_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        got = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk_i);
            if (!req_ready_o) nrdy++;
            if (resp_valid_o) begin
                got = 1'b1;
                lat = k;
                ins = resp_instr_o;
                er  = resp_err_o;
            end
        end
        if (!got) timeout("resp_wait");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        n_err++;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        int          lat, nrdy, nv, idx;
        logic [31:0] ins;
        logic        er;
        bit          acc, got;
        int          rc [3];
        logic [31:0] ri [3];
        int          n;

        rst_i = 1'b0; req_valid_i = 1'b0; req_addr_i = 32'h0; flush_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]           = mem_val(i);
            dut.u_array.mem[i]   = mem_val(i);
        end
        #2;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_instr", resp_instr_o, 32'h0);
        chk("rst_err", 32'(resp_err_o), 32'd0);
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;

        // Single fetch of word 0
        do_req(32'h0, lat, ins, er, nrdy);
        chk("t1_lat", 32'(lat), 32'd3);
        chk("t1_nrdy", 32'(nrdy), 32'd3);
        chk("t1_instr", ins, 32'h2001_0005);
        chk("t1_err", 32'(er), 32'd0);

        // Back-to-back 0,4,8 with valid held high
        @(posedge clk_i); #1;
        req_valid_i = 1'b1; req_addr_i = 32'h0; idx = 0; n = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk_i);
            if (resp_valid_o && n < 3) begin
                rc[n] = c; ri[n] = resp_instr_o; n++;
            end
            acc = req_valid_i && req_ready_o;
            @(posedge clk_i); #1;
            if (acc) begin
                idx++;
                if (idx < 3) req_addr_i = 32'(idx * 4);
                else         req_valid_i = 1'b0;
            end
        end
        chk("t2_count", 32'(n), 32'd3);
        if (n == 3) begin
            chk("t2_gap01", 32'(rc[1] - rc[0]), 32'(B2B_GAP));
            chk("t2_gap12", 32'(rc[2] - rc[1]), 32'(B2B_GAP));
            chk("t2_instr0", ri[0], 32'h2001_0005);
            chk("t2_instr1", ri[1], 32'h2002_000A);
            chk("t2_instr2", ri[2], 32'h0043_1820);
        end

        // Error requests and the last legal word
        do_req(32'h6, lat, ins, er, nrdy);
        chk("t3_mis_lat", 32'(lat), 32'd1);
        chk("t3_mis_err", 32'(er), 32'd1);
        chk("t3_mis_instr", ins, 32'h0);
        do_req(32'(4 * DEPTH), lat, ins, er, nrdy);
        chk("t3_oor_lat", 32'(lat), 32'd1);
        chk("t3_oor_err", 32'(er), 32'd1);
        chk("t3_oor_instr", ins, 32'h0);
        do_req(32'(4 * DEPTH - 4), lat, ins, er, nrdy);
        chk("t3_last_lat", 32'(lat), 32'd3);
        chk("t3_last_err", 32'(er), 32'd0);
        chk("t3_last_instr", ins, 32'h1234_5678);

        // Flush one cycle after accept
        @(posedge clk_i); #1;
        req_valid_i = 1'b1; req_addr_i = 32'h8; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk_i);
            got = req_ready_o;
        end
        if (!got) timeout("t4_accept");
        @(posedge clk_i); #1;
        req_valid_i = 1'b0; flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        nv = 0;
        @(negedge clk_i);
        chk("t4_idle_ready", 32'(req_ready_o), 32'd1);
        if (resp_valid_o) nv++;
        repeat (5) begin
            @(negedge clk_i);
            if (resp_valid_o) nv++;
        end
        chk("t4_no_resp", 32'(nv), 32'd0);
        do_req(32'hC, lat, ins, er, nrdy);
        chk("t4_next_lat", 32'(lat), 32'd3);
        chk("t4_next_instr", ins, 32'hAC03_0010);

        // Reset asserted while waiting
        @(posedge clk_i); #1;
        req_valid_i = 1'b1; req_addr_i = 32'h10; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk_i);
            got = req_ready_o;
        end
        if (!got) timeout("t5_accept");
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        rst_i = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(req_ready_o), 32'd1);
        chk("t5_rst_valid", 32'(resp_valid_o), 32'd0);
        chk("t5_rst_instr", resp_instr_o, 32'h0);
        chk("t5_rst_err", 32'(resp_err_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        nv = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (resp_valid_o) nv++;
        end
        chk("t5_no_resp", 32'(nv), 32'd0);
        do_req(32'h10, lat, ins, er, nrdy);
        chk("t5_next_lat", 32'(lat), 32'd3);
        chk("t5_next_instr", ins, 32'h8C04_0020);

`ifdef IMEM_PREFETCH_EN
        // Prefetch hit then miss
        do_req(32'h0, lat, ins, er, nrdy);
        chk("t6_first_lat", 32'(lat), 32'd3);
        chk("t6_first_instr", ins, 32'h2001_0005);
        do_req(32'h4, lat, ins, er, nrdy);
        chk("t6_hit_lat", 32'(lat), 32'd1);
        chk("t6_hit_instr", ins, 32'h2002_000A);
        do_req(32'hC, lat, ins, er, nrdy);
        chk("t6_miss_lat", 32'(lat), 32'd3);
        chk("t6_miss_instr", ins, 32'hAC03_0010);
`endif

        repeat (3) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
